// File: rtl/fpu_div16_if.sv
// Start/done handshake and operand/result bus of the FP16 divide coprocessor.
interface fpu_div16_if;
   logic        start;
   logic [15:0] fpuIn1;
   logic [15:0] fpuIn2;
   logic [15:0] fpuOut;
   logic        done;
   logic [3:0]  condCodes;
   logic [4:0]  opStatusFlags;

   modport master (output start, fpuIn1, fpuIn2,
                   input  fpuOut, done, condCodes, opStatusFlags);
   modport slave  (input  start, fpuIn1, fpuIn2,
                   output fpuOut, done, condCodes, opStatusFlags);
endinterface

// File: rtl/fpu_div16.sv
// Sequential FP16 divider: special-case bypass, subnormal pre-normalization,
// restoring bit-serial significand divide, then one round-to-nearest-even/pack cycle.
module fpu_div16 #(
   parameter int QUOTW = 14
) (
   input logic        clock,
   input logic        reset,
   fpu_div16_if.slave bus
);

   localparam int CNTW = $clog2(QUOTW);

   typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

   state_t                  state, nextState;
   logic [14:0]             opA, opB;
   logic                    sign;
   logic signed [7:0]       expE;
   logic [11:0]             remR;
   logic [10:0]             divD;
   logic [QUOTW-1:0]        quot;
   logic [CNTW-1:0]         cnt;
   logic [15:0]             outR;
   logic [4:0]              flagsR;

   logic                    nanA, nanB, infA, infB, zeroA, zeroB, isSpecial, inSign;
   logic [15:0]             specOut;
   logic [4:0]              specFlags;
   logic [10:0]             sigA, sigB, normA, normB;
   logic [3:0]              shA, shB;
   logic signed [7:0]       effA, effB, expNorm;

   function automatic logic [3:0] lzc11(input logic [10:0] s);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i <= 10; i++)
         if (s[i]) n = 4'(10 - i);
      return n;
   endfunction

   // Returns {flags[4:0], result[15:0]}; mant holds {significand, guard}.
   function automatic logic [20:0] roundPack(input logic s, input logic [QUOTW-1:0] qIn,
                                             input logic remNz, input logic signed [7:0] eIn);
      logic [QUOTW-1:0]  q;
      logic signed [7:0] e;
      logic [11:0]       mant, lowMask, res;
      logic [7:0]        shamt;
      logic              sticky, tiny, inexact, rnd, ovf;
      logic [15:0]       word;
      q = qIn;
      e = eIn;
      if (!q[QUOTW-1]) begin
         q = q << 1;
         e = e - 8'sd1;
      end
      mant    = q[QUOTW-1 -: 12];
      sticky  = remNz | (|q[QUOTW-13:0]);
      tiny    = (e <= 8'sd0);
      ovf     = 1'b0;
      shamt   = 8'(8'sd1 - e);
      lowMask = (12'd1 << shamt[3:0]) - 12'd1;
      if (e >= 8'sd31) return {5'b00101, s, 5'h1F, 10'h000};
      if (tiny) begin
         if (shamt >= 8'd13) begin
            sticky = sticky | (|mant);
            mant   = 12'h000;
         end else begin
            sticky = sticky | (|(mant & lowMask));
            mant   = mant >> shamt[3:0];
         end
      end
      rnd     = mant[0] & (sticky | mant[1]);
      res     = {1'b0, mant[11:1]} + {11'h000, rnd};
      inexact = mant[0] | sticky;
      // A subnormal that rounds up to 0x400 lands exactly on the smallest normal encoding.
      if (tiny)
         word = {s, 4'h0, res[10:0]};
      else if (res[11]) begin
         if (e == 8'sd30) begin
            word = {s, 5'h1F, 10'h000};
            ovf  = 1'b1;
         end else begin
            word = {s, 5'(e + 8'sd1), 10'h000};
         end
      end else begin
         word = {s, e[4:0], res[9:0]};
      end
      return {2'b00, ovf, tiny & inexact, inexact, word};
   endfunction

   assign nanA   = (bus.fpuIn1[14:10] == 5'h1F) && (bus.fpuIn1[9:0] != 10'h0);
   assign nanB   = (bus.fpuIn2[14:10] == 5'h1F) && (bus.fpuIn2[9:0] != 10'h0);
   assign infA   = (bus.fpuIn1[14:0] == 15'h7C00);
   assign infB   = (bus.fpuIn2[14:0] == 15'h7C00);
   assign zeroA  = (bus.fpuIn1[14:0] == 15'h0000);
   assign zeroB  = (bus.fpuIn2[14:0] == 15'h0000);
   assign inSign = bus.fpuIn1[15] ^ bus.fpuIn2[15];
   assign isSpecial = nanA | nanB | infA | infB | zeroA | zeroB;

   always_comb begin
      specOut   = 16'h0000;
      specFlags = 5'b00000;
      if (nanA | nanB | (zeroA & zeroB) | (infA & infB)) begin
         specOut   = 16'h7E00;
         specFlags = 5'b10000;
      end else if (infA) begin
         specOut = {inSign, 5'h1F, 10'h000};
      end else if (zeroB) begin
         specOut   = {inSign, 5'h1F, 10'h000};
         specFlags = 5'b01000;
      end else if (infB | zeroA) begin
         specOut = {inSign, 15'h0000};
      end
   end

   assign sigA    = {opA[14:10] != 5'd0, opA[9:0]};
   assign sigB    = {opB[14:10] != 5'd0, opB[9:0]};
   assign shA     = lzc11(sigA);
   assign shB     = lzc11(sigB);
   assign normA   = sigA << shA;
   assign normB   = sigB << shB;
   assign effA    = $signed({3'b000, (opA[14:10] == 5'd0) ? 5'd1 : opA[14:10]}) - $signed({4'b0000, shA});
   assign effB    = $signed({3'b000, (opB[14:10] == 5'd0) ? 5'd1 : opB[14:10]}) - $signed({4'b0000, shB});
   assign expNorm = effA - effB + 8'sd15;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: if (bus.start) nextState = isSpecial ? DONE : NORM;
         NORM:       nextState = DIV;
         DIV:        if (cnt == '0) nextState = ROUND;
         ROUND:      nextState = DONE;
         default:    nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         opA    <= '0;
         opB    <= '0;
         sign   <= 1'b0;
         expE   <= '0;
         remR   <= '0;
         divD   <= '0;
         quot   <= '0;
         cnt    <= '0;
         outR   <= '0;
         flagsR <= '0;
      end else begin
         case (state)
            // operand capture; specials resolve on this same edge
            IDLE, DONE: begin
               if (bus.start) begin
                  opA  <= bus.fpuIn1[14:0];
                  opB  <= bus.fpuIn2[14:0];
                  sign <= inSign;
                  if (isSpecial) begin
                     outR   <= specOut;
                     flagsR <= specFlags;
                  end
               end
            end
            // normalized significands and biased quotient exponent
            NORM: begin
               remR <= {1'b0, normA};
               divD <= normB;
               expE <= expNorm;
               quot <= '0;
               cnt  <= CNTW'(QUOTW - 1);
            end
            // one restoring quotient bit per cycle, MSB first
            DIV: begin
               if (remR >= {1'b0, divD}) begin
                  quot <= {quot[QUOTW-2:0], 1'b1};
                  remR <= (remR - {1'b0, divD}) << 1;
               end else begin
                  quot <= {quot[QUOTW-2:0], 1'b0};
                  remR <= remR << 1;
               end
               cnt <= cnt - 1'b1;
            end
            // round and pack
            ROUND: {flagsR, outR} <= roundPack(sign, quot, remR != 12'h000, expE);
            default: ;
         endcase
      end
   end

   assign bus.fpuOut        = outR;
   assign bus.done          = (state == DONE);
   assign bus.opStatusFlags = flagsR;
   assign bus.condCodes     = {outR == 16'h0000, 1'b0, outR[15], 1'b0};

endmodule

// File: tb/tb_fpu_div16.sv
// Scoreboard bench for fpu_div16: directed cases plus random operands against an exact-quotient model.
module tb_fpu_div16;

   logic clock;
   logic reset;
   longint cycle;
   int checks;
   int errors;

   fpu_div16_if bus();

   fpu_div16 #(.QUOTW(14)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] out;
      logic [4:0]  flg;
      int          lat;
      longint      issue;
   } exp_t;

   exp_t scb[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cycle = 0;
   always @(posedge clock) cycle <= cycle + 1;

   task automatic cmp(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s op=%h/%h got %h expected %h", nm, a, b, got, want);
      end
   endtask

   function automatic logic isSpec(input logic [15:0] a, input logic [15:0] b);
      return (a[14:10] == 5'h1F) || (b[14:10] == 5'h1F) ||
             (a[14:0] == 15'h0) || (b[14:0] == 15'h0);
   endfunction

   // Exact quotient from integer division, then IEEE RNE onto the FP16 grid.
   function automatic logic [20:0] refDiv(input logic [15:0] a, input logic [15:0] b);
      logic s, nanA, nanB, infA, infB, zA, zB, inx, tiny, rnd;
      longint unsigned ma, mb, qi, rem, kept, low, half, m;
      int ea, eb, sc, p, xx, u, k, fld;
      logic [15:0] o;
      logic [4:0] f;
      s    = a[15] ^ b[15];
      nanA = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      nanB = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      infA = (a[14:0] == 15'h7C00);
      infB = (b[14:0] == 15'h7C00);
      zA   = (a[14:0] == 15'h0);
      zB   = (b[14:0] == 15'h0);
      if (nanA || nanB || (zA && zB) || (infA && infB)) return {5'b10000, 16'h7E00};
      if (infA) return {5'b00000, s, 15'h7C00};
      if (zB)   return {5'b01000, s, 15'h7C00};
      if (infB || zA) return {5'b00000, s, 15'h0000};
      ma = (a[14:10] == 0) ? longint'(a[9:0]) : 1024 + longint'(a[9:0]);
      mb = (b[14:10] == 0) ? longint'(b[9:0]) : 1024 + longint'(b[9:0]);
      ea = (a[14:10] == 0) ? -24 : int'(a[14:10]) - 25;
      eb = (b[14:10] == 0) ? -24 : int'(b[14:10]) - 25;
      qi  = (ma << 40) / mb;
      rem = (ma << 40) % mb;
      sc  = ea - eb - 40;
      p = 0;
      for (int i = 0; i < 64; i++) if (qi[i]) p = i;
      xx   = p + sc;
      tiny = (xx < -14);
      u    = tiny ? -24 : xx - 10;
      k    = u - sc;
      kept = qi >> k;
      low  = qi & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      inx  = (low != 0) || (rem != 0);
      rnd  = (low > half) || ((low == half) && ((rem != 0) || kept[0]));
      m    = kept + longint'(rnd);
      if (tiny) begin
         o = {s, 15'(m)};
         f = {3'b000, inx, inx};
      end else begin
         if (m == 2048) begin
            m = 1024;
            u++;
         end
         fld = u + 25;
         if (fld >= 31) begin
            o = {s, 15'h7C00};
            f = 5'b00101;
         end else begin
            o = {s, 5'(fld), m[9:0]};
            f = {4'b0000, inx};
         end
      end
      return {f, o};
   endfunction

   function automatic logic [15:0] randOp();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 9))
         0: x[14:10] = 5'd0;
         1: x[14:0] = x[0] ? 15'h7C00 : 15'h0000;
         2: x[14:10] = 5'h1F;
         3: x[14:10] = 5'($urandom_range(26, 30));
         4: x[14:10] = 5'($urandom_range(1, 4));
         default: ;
      endcase
      return x;
   endfunction

   always @(negedge clock) begin
      if (reset && scb.size() > 0 && cycle >= scb[0].issue) begin
         if (bus.done) begin
            exp_t e;
            e = scb.pop_front();
            cmp("fpuOut", e.a, e.b, bus.fpuOut, e.out);
            cmp("flags", e.a, e.b, {11'h0, bus.opStatusFlags}, {11'h0, e.flg});
            cmp("condCodes", e.a, e.b, {12'h0, bus.condCodes},
                {12'h0, e.out == 16'h0, 1'b0, e.out[15], 1'b0});
            cmp("latency", e.a, e.b, 16'(cycle - e.issue), 16'(e.lat));
         end else if (cycle - scb[0].issue > 40) begin
            exp_t e;
            e = scb.pop_front();
            checks++;
            errors++;
            $display("FAIL timeout op=%h/%h no done within 40 cycles", e.a, e.b);
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] wantOut, input logic [4:0] wantFlg, input logic poke);
      exp_t e;
      int guard;
      @(posedge clock); #2;
      bus.start  = 1'b1;
      bus.fpuIn1 = a;
      bus.fpuIn2 = b;
      e.a = a;
      e.b = b;
      e.out = wantOut;
      e.flg = wantFlg;
      e.lat = isSpec(a, b) ? 0 : 16;
      e.issue = cycle + 1;
      scb.push_back(e);
      @(posedge clock); #2;
      bus.start  = 1'b0;
      bus.fpuIn1 = 16'($urandom);
      bus.fpuIn2 = 16'($urandom);
      guard = 0;
      while (scb.size() != 0 && guard < 60) begin
         @(posedge clock); #2;
         guard++;
         // a start pulse mid-divide must be ignored
         bus.start = (poke && e.lat == 16 && guard == 3);
      end
      bus.start = 1'b0;
   endtask

   task automatic issueRand();
      logic [15:0] a, b;
      logic [20:0] r;
      a = randOp();
      b = randOp();
      r = refDiv(a, b);
      issue(a, b, r[15:0], r[20:16], $urandom_range(0, 3) == 0);
   endtask

   localparam int NDIR = 13;
   localparam logic [15:0] DIR_A [NDIR] = '{16'h4600, 16'h3C00, 16'hBC00, 16'h3C00, 16'h0000,
                                             16'h7C00, 16'h3C00, 16'h7BFF, 16'h0400, 16'h0001,
                                             16'h0200, 16'h7E00, 16'hFC00};
   localparam logic [15:0] DIR_B [NDIR] = '{16'h4200, 16'h4200, 16'h4000, 16'h0000, 16'h0000,
                                             16'h7C00, 16'h7C00, 16'h3800, 16'h4000, 16'h4000,
                                             16'h3800, 16'h3C00, 16'h4000};
   localparam logic [15:0] DIR_O [NDIR] = '{16'h4000, 16'h3555, 16'hB800, 16'h7C00, 16'h7E00,
                                             16'h7E00, 16'h0000, 16'h7C00, 16'h0200, 16'h0000,
                                             16'h0400, 16'h7E00, 16'hFC00};
   localparam logic [4:0]  DIR_F [NDIR] = '{5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b10000,
                                             5'b10000, 5'b00000, 5'b00101, 5'b00000, 5'b00011,
                                             5'b00000, 5'b10000, 5'b00000};

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.start  = 1'b0;
      bus.fpuIn1 = 16'h0;
      bus.fpuIn2 = 16'h0;
      repeat (2) @(posedge clock);
      #1;
      cmp("rstDone", 16'h0, 16'h0, {15'h0, bus.done}, 16'h0);
      cmp("rstOut", 16'h0, 16'h0, bus.fpuOut, 16'h0);
      cmp("rstFlags", 16'h0, 16'h0, {11'h0, bus.opStatusFlags}, 16'h0);
      @(posedge clock); #2;
      reset = 1'b1;

      for (int i = 0; i < NDIR; i++)
         issue(DIR_A[i], DIR_B[i], DIR_O[i], DIR_F[i], 1'b0);

      // abort a divide in flight while the previous nonzero result is still held
      issue(16'h4600, 16'h4200, 16'h4000, 5'b00000, 1'b0);
      @(posedge clock); #2;
      bus.start  = 1'b1;
      bus.fpuIn1 = 16'h3C00;
      bus.fpuIn2 = 16'h4200;
      @(posedge clock); #2;
      bus.start = 1'b0;
      repeat (6) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      cmp("abortDone", 16'h3C00, 16'h4200, {15'h0, bus.done}, 16'h0);
      cmp("abortOut", 16'h3C00, 16'h4200, bus.fpuOut, 16'h0);
      cmp("abortFlags", 16'h3C00, 16'h4200, {11'h0, bus.opStatusFlags}, 16'h0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      issue(16'h4600, 16'h4200, 16'h4000, 5'b00000, 1'b0);
      issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 1'b0);

      for (int n = 0; n < 300; n++) issueRand();

      repeat (5) @(posedge clock);
      if (scb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d expected 0", scb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
